quan_sum_mult_e_vecop_v4: RTL and testbench
===========================================

QUAN_SUM_MULT_E_VECOP_V4 -- requirements
Module: quan_sum_mult_E_vecOp_v4

Interface
REQ-001 SHALL have parameters: column_num_in_sa 16, columns per SA; pe_parallel_pixel 2, pixels per PE; max_ch 4, max weight channels; E_width 16, E tail width; mult_A_width 24; mult_B_width 16; lane_bits 48, sum bits per pixel lane.
REQ-002 SHALL derive L = pe_parallel_pixel*column_num_in_sa (32), SUM_W = L*lane_bits (1536), A_W = mult_A_width*max_ch*L (3072), B_W = mult_B_width*max_ch*L (2048).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  4  0 = 8x8 (1 ch, 24b), 1 = 1x8 (2 ch, 16b), 2 = 1x4 (4 ch, 12b), others illegal
- E_load  in  1  write E_set_in to E bank
- E_set_in  in  E_width*max_ch  channel c at [c*E_width +: E_width]
- in_valid  in  1  sum_vector/mode valid
- in_ready  out  1  input accepted when in_valid && in_ready
- sum_vector  in  SUM_W  channel-major packed sums
- out_valid  out  1  outputs valid
- out_ready  in  1  downstream accepts
- sum_vector_in_mult_A_width  out  A_W  lane (c*L+p) at [(c*L+p)*mult_A_width +: mult_A_width]
- E_vector_in_mult_B_width  out  B_W  same lane indexing
- illegal_mode_cnt  out  8  saturating illegal-mode count

Function
REQ-004 SHALL define per mode: W = 24/16/12 and C = 1/2/4 (modes 0/1/2); channel c, pixel p source = sum_vector[(c*L+p)*W +: W].
REQ-005 SHALL sign-extend each source to mult_A_width; mode 0 copies 24 bits unchanged.
REQ-006 SHALL drive A lanes of channels c >= C with zero.
REQ-007 SHALL drive B lane (c,p) with {zeros, E_bank[c]} for c < C, zero for c >= C.
REQ-008 SHALL, for an illegal mode, output all-zero A and B, still handshake the transaction, and increment illegal_mode_cnt (saturates at 255).
REQ-009 SHALL hold E_bank (max_ch x E_width) in registers, written on E_load from E_set_in.
REQ-010 SHALL snapshot mode and E_bank at acceptance; if E_load and acceptance coincide, the transaction uses the new E_set_in (write-through).
REQ-011 SHALL pipeline in two stages: S1 registers sum_vector, mode, E snapshot; S2 formats and registers outputs.
REQ-012 SHALL compute s2_en = !out_valid || out_ready, s1_en = !s1_valid || s2_en, in_ready = s1_en (combinational, no in_valid dependence).
REQ-013 SHALL give latency 2: transaction accepted at edge k has out_valid high after edge k+1; with out_ready held high, throughput 1 per cycle.
REQ-014 SHALL hold outputs and out_valid stable while out_valid && !out_ready; no transaction lost or duplicated.
REQ-015 SHALL collapse bubbles: an empty S1 or S2 accepts new data even when downstream stalls.
REQ-016 SHALL register all data outputs (no combinational path from sum_vector to output).

Reset
REQ-017 SHALL on rst_n low asynchronously clear s1_valid, out_valid, illegal_mode_cnt, E_bank, and both output vectors to zero.
REQ-018 SHALL drop in-flight transactions on reset mid-operation; first valid out after release is a post-reset transaction.
REQ-019 SHALL drive in_ready high in the first cycle after reset release.

Verification
REQ-020 Mode 0, E_set_in lane0 = 0x1234 loaded, sum lane p = p-1 (24b) -> after 2 edges A lane0 = 0xFFFFFF, lane1 = 0x000000, B lanes 0..31 = 0x1234, lanes 32..127 = 0.
REQ-021 Mode 2, channel 3 pixel 5 = 12'h800, E ch3 = 0xABCD -> A lane 101 = 0xFFF800, B lane 101 = 0xABCD; mode 1 same data -> lanes 64..127 zero.
REQ-022 Back-to-back 4 transactions, out_ready low 3 cycles after first out_valid -> in_ready low after 2 more accepts, outputs stable, all 4 delivered in order.
REQ-023 E_load with new E on the accept cycle -> that transaction carries new E; previous in-flight transaction keeps old E.
REQ-024 Mode 5 x 300 transactions -> outputs zero, out_valid asserted each time, illegal_mode_cnt = 255.
REQ-025 rst_n low while S1 and S2 full -> out_valid 0 immediately, outputs zero, in_ready 1 after release.

Source files
------------

// File: rtl/quan_sum_mult_e_vecop_v4.sv
// Unpacks quantised per-pixel sums and E tails into multiplier-width lanes (8x8 / 1x8 / 1x4 modes).
// Latency: 2 cycles from acceptance to out_valid; throughput 1 per cycle.
// Backpressure: valid/ready, two-stage skid-free pipeline with bubble collapse; outputs held while stalled.
module quan_sum_mult_e_vecop_v4 #(
    parameter int column_num_in_sa  = 16,
    parameter int pe_parallel_pixel = 2,
    parameter int max_ch            = 4,
    parameter int E_width           = 16,
    parameter int mult_A_width      = 24,
    parameter int mult_B_width      = 16,
    parameter int lane_bits         = 48,
    localparam int L     = pe_parallel_pixel * column_num_in_sa,
    localparam int SUM_W = L * lane_bits,
    localparam int A_W   = mult_A_width * max_ch * L,
    localparam int B_W   = mult_B_width * max_ch * L
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  mode,
    input  logic                        E_load,
    input  logic [E_width*max_ch-1:0]   E_set_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SUM_W-1:0]            sum_vector,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [A_W-1:0]              sum_vector_in_mult_A_width,
    output logic [B_W-1:0]              E_vector_in_mult_B_width,
    output logic [7:0]                  illegal_mode_cnt
);

    typedef struct packed {
        logic [3:0]                mode;
        logic [E_width*max_ch-1:0] e;
        logic [SUM_W-1:0]          sum;
    } s1_t;

    logic [E_width*max_ch-1:0] e_bank;
    logic [E_width*max_ch-1:0] e_snap;
    s1_t                       s1_q;
    logic                      s1_valid;
    logic                      s1_en;
    logic                      s2_en;
    logic                      illegal;
    logic [A_W-1:0]            a_fmt;
    logic [B_W-1:0]            b_fmt;
    int                        ch_act;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // A load coinciding with acceptance must be seen by that transaction.
    assign e_snap  = E_load ? E_set_in : e_bank;
    assign illegal = s1_q.mode > 4'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_bank <= '0;
        end else if (E_load) begin
            e_bank <= E_set_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q.mode <= mode;
                s1_q.e    <= e_snap;
                s1_q.sum  <= sum_vector;
            end
        end
    end

    always_comb begin
        a_fmt  = '0;
        b_fmt  = '0;
        ch_act = 0;
        case (s1_q.mode)
            4'd0: begin
                ch_act = 1;
                for (int i = 0; i < L; i++) begin
                    a_fmt[i*mult_A_width +: mult_A_width] =
                        mult_A_width'($signed(s1_q.sum[i*24 +: 24]));
                end
            end
            4'd1: begin
                ch_act = 2;
                for (int i = 0; i < 2*L; i++) begin
                    a_fmt[i*mult_A_width +: mult_A_width] =
                        mult_A_width'($signed(s1_q.sum[i*16 +: 16]));
                end
            end
            4'd2: begin
                ch_act = 4;
                for (int i = 0; i < 4*L; i++) begin
                    a_fmt[i*mult_A_width +: mult_A_width] =
                        mult_A_width'($signed(s1_q.sum[i*12 +: 12]));
                end
            end
            default: ch_act = 0;
        endcase
        // Lane i belongs to channel i/L; inactive channels stay zero.
        for (int i = 0; i < max_ch*L; i++) begin
            if (i < ch_act*L) begin
                b_fmt[i*mult_B_width +: mult_B_width] =
                    mult_B_width'(s1_q.e[(i/L)*E_width +: E_width]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid                  <= 1'b0;
            sum_vector_in_mult_A_width <= '0;
            E_vector_in_mult_B_width   <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum_vector_in_mult_A_width <= a_fmt;
                E_vector_in_mult_B_width   <= b_fmt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_mode_cnt <= 8'd0;
        end else if (s2_en && s1_valid && illegal && illegal_mode_cnt != 8'hFF) begin
            illegal_mode_cnt <= illegal_mode_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_quan_sum_mult_e_vecop_v4.sv
// Directed bench for quan_sum_mult_e_vecop_v4: vector table plus backpressure, write-through, illegal-mode and reset sequences.
module tb_quan_sum_mult_e_vecop_v4;

    localparam int L     = 32;
    localparam int SUM_W = 1536;
    localparam int A_W   = 3072;
    localparam int B_W   = 2048;
    localparam logic [63:0] E_ALL = {16'hABCD, 16'h3333, 16'h2222, 16'h1234};

    logic             clk;
    logic             rst_n;
    logic [3:0]       mode;
    logic             E_load;
    logic [63:0]      E_set_in;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_vector;
    logic             out_valid;
    logic             out_ready;
    logic [A_W-1:0]   a_vec;
    logic [B_W-1:0]   b_vec;
    logic [7:0]       illegal_mode_cnt;

    int checks = 0;
    int errors = 0;

    quan_sum_mult_e_vecop_v4 dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .mode                       (mode),
        .E_load                     (E_load),
        .E_set_in                   (E_set_in),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .sum_vector                 (sum_vector),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .sum_vector_in_mult_A_width (a_vec),
        .E_vector_in_mult_B_width   (b_vec),
        .illegal_mode_cnt           (illegal_mode_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] mk_sum(input int pat);
        logic [SUM_W-1:0] v;
        v = '0;
        case (pat)
            0: for (int i = 0; i < 32; i++) v[i*24 +: 24] = 24'(i - 1);
            1: v[101*12 +: 12] = 12'h800;
            2: for (int i = 0; i < 64; i++) v[i*16 +: 16] = 16'h8000 | 16'(i);
            3: for (int i = 0; i < 128; i++) v[i*12 +: 12] = 12'(i);
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [SUM_W-1:0] tag_sum(input int tag);
        logic [SUM_W-1:0] v;
        v = '0;
        v[23:0] = 24'(tag);
        return v;
    endfunction

    function automatic logic [23:0] a_lane(input int lane);
        return a_vec[lane*24 +: 24];
    endfunction

    function automatic logic [15:0] b_lane(input int lane);
        return b_vec[lane*16 +: 16];
    endfunction

    typedef struct {
        logic [3:0]  mode;
        int          pat;
        int          lane;
        logic [23:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    initial begin
        int sent;
        int recv;
        int first_ov;
        int got;
        int bad;
        logic prev_hold;
        logic [23:0] prev_a;

        tv[0]  = '{4'd0, 0, 0,   24'hFFFFFF, 16'h1234};
        tv[1]  = '{4'd0, 0, 1,   24'h000000, 16'h1234};
        tv[2]  = '{4'd0, 0, 31,  24'h00001E, 16'h1234};
        tv[3]  = '{4'd0, 0, 32,  24'h000000, 16'h0000};
        tv[4]  = '{4'd0, 0, 127, 24'h000000, 16'h0000};
        tv[5]  = '{4'd2, 1, 101, 24'hFFF800, 16'hABCD};
        tv[6]  = '{4'd2, 1, 100, 24'h000000, 16'hABCD};
        tv[7]  = '{4'd2, 1, 5,   24'h000000, 16'h1234};
        tv[8]  = '{4'd1, 1, 101, 24'h000000, 16'h0000};
        tv[9]  = '{4'd1, 1, 40,  24'h000000, 16'h2222};
        tv[10] = '{4'd1, 2, 33,  24'hFF8021, 16'h2222};
        tv[11] = '{4'd1, 2, 64,  24'h000000, 16'h0000};
        tv[12] = '{4'd1, 2, 2,   24'hFF8002, 16'h1234};
        tv[13] = '{4'd2, 3, 127, 24'h00007F, 16'hABCD};
        tv[14] = '{4'd2, 3, 70,  24'h000046, 16'h3333};
        tv[15] = '{4'd2, 3, 32,  24'h000020, 16'h2222};
        tv[16] = '{4'd0, 3, 5,   24'h00B00A, 16'h1234};

        rst_n = 1'b0; mode = 4'd0; E_load = 1'b0; E_set_in = '0;
        in_valid = 1'b0; sum_vector = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a_zero", 64'(a_vec == '0), 64'd1);
        check("rst_b_zero", 64'(b_vec == '0), 64'd1);
        check("rst_cnt", 64'(illegal_mode_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            mode = tv[k].mode; sum_vector = mk_sum(tv[k].pat);
            E_load = 1'b1; E_set_in = E_ALL; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; E_load = 1'b0;
            check($sformatf("tv%0d_early_valid", k), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("tv%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("tv%0d_a_lane%0d", k, tv[k].lane), 64'(a_lane(tv[k].lane)), 64'(tv[k].exp_a));
            check($sformatf("tv%0d_b_lane%0d", k, tv[k].lane), 64'(b_lane(tv[k].lane)), 64'(tv[k].exp_b));
        end
        check("legal_cnt", 64'(illegal_mode_cnt), 64'd0);

        // Back-to-back four with a three-cycle stall once output appears.
        sent = 0; recv = 0; first_ov = -1; prev_hold = 1'b0; prev_a = '0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_data", 64'(a_lane(0)), 64'(prev_a));
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            out_ready = !(first_ov >= 0 && cyc < first_ov + 3);
            in_valid = (sent < 4); mode = 4'd0; E_load = 1'b0;
            sum_vector = tag_sum(sent + 1);
            #1;
            if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check($sformatf("order_%0d", recv), 64'(a_lane(0)), 64'(recv + 1));
                recv++;
            end
            prev_hold = out_valid && !out_ready;
            prev_a = a_lane(0);
        end
        check("stall_delivered", 64'(recv), 64'd4);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // E write-through: second transaction loads new E on its accept cycle.
        @(negedge clk);
        mode = 4'd0; sum_vector = tag_sum(21); in_valid = 1'b1; E_load = 1'b0;
        @(negedge clk);
        sum_vector = tag_sum(22); E_load = 1'b1;
        E_set_in = {16'hABCD, 16'h3333, 16'h2222, 16'h5555};
        @(negedge clk);
        in_valid = 1'b0; E_load = 1'b0;
        check("wt_old_valid", 64'(out_valid), 64'd1);
        check("wt_old_tag", 64'(a_lane(0)), 64'd21);
        check("wt_old_e", 64'(b_lane(0)), 64'h1234);
        @(negedge clk);
        check("wt_new_valid", 64'(out_valid), 64'd1);
        check("wt_new_tag", 64'(a_lane(0)), 64'd22);
        check("wt_new_e", 64'(b_lane(31)), 64'h5555);

        // 300 illegal-mode transactions at full rate.
        sent = 0; got = 0; bad = 0;
        for (int cyc = 0; cyc < 320 && got < 300; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 300); mode = 4'd5; sum_vector = mk_sum(3); out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                got++;
                if (a_vec != '0 || b_vec != '0) bad++;
            end
        end
        in_valid = 1'b0;
        check("illegal_delivered", 64'(got), 64'd300);
        check("illegal_zero_out", 64'(bad), 64'd0);
        check("illegal_cnt_sat", 64'(illegal_mode_cnt), 64'd255);

        // Reset while both stages hold data.
        @(negedge clk);
        out_ready = 1'b0; mode = 4'd0; in_valid = 1'b1; sum_vector = tag_sum(7);
        @(negedge clk);
        sum_vector = tag_sum(8);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_a", 64'(a_vec == '0), 64'd1);
        check("mid_rst_b", 64'(b_vec == '0), 64'd1);
        check("mid_rst_cnt", 64'(illegal_mode_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b1; sum_vector = tag_sum(9);
        @(negedge clk);
        in_valid = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 6 && got == 0; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                check("post_rst_first_tag", 64'(a_lane(0)), 64'd9);
                check("post_rst_e_cleared", 64'(b_lane(0)), 64'd0);
            end
        end
        check("post_rst_delivered", 64'(got), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
